// File: rtl/fetch_if.sv
// ----------------------------------------------------------------------------
// fetch_if
//   Groups the fetch front end's bus signals: the instruction-memory read port,
//   the decode-side valid/ready output and the redirect request.
//   master : the fetch unit (drives imem_en/imem_addr and out_*)
//   slave  : the environment (memory, decode and redirect source)
// Parameters
//   PC_W    word-address width
//   INSTR_W instruction width
// ----------------------------------------------------------------------------
interface fetch_if #(
    parameter int PC_W    = 15,
    parameter int INSTR_W = 32
);
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        output imem_en, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, out_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, out_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. Issues word-addressed reads to a synchronous
//   instruction memory with MEM_LAT cycles of latency, tracks in-flight reads
//   with a {valid,pc} tag pipeline, buffers returned words in a DEPTH-entry
//   prefetch FIFO and presents {instr, pc} to decode with valid/ready.
//   A redirect flushes the FIFO and all in-flight reads and restarts fetch.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   bus          fetch_if.master: imem_en/imem_addr/imem_rdata,
//                out_valid/out_ready/out_instr/out_pc, redirect/redirect_pc
//   fetch_count  [FETCH_STATS_EN] instructions popped by decode
//   flush_count  [FETCH_STATS_EN] instructions discarded by redirects
// Configuration macro: FETCH_STATS_EN adds the two statistics counters.
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              PC_W     = 15,
    parameter int              INSTR_W  = 32,
    parameter int              MEM_LAT  = 2,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = {{(PC_W-1){1'b1}}, 1'b0}
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               tag_valid_q [MEM_LAT];
    logic               tag_valid_d [MEM_LAT];
    logic [PC_W-1:0]    tag_pc_q    [MEM_LAT];
    logic [PC_W-1:0]    tag_pc_d    [MEM_LAT];
    logic [INSTR_W-1:0] fifo_instr_q [DEPTH];
    logic [INSTR_W-1:0] fifo_instr_d [DEPTH];
    logic [PC_W-1:0]    fifo_pc_q    [DEPTH];
    logic [PC_W-1:0]    fifo_pc_d    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W:0]     credit_used;
    logic               issue, push, pop;

    // Reads already issued count against FIFO space, so every returning word
    // is guaranteed a slot even if decode stalls.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_valid_q[i]);
        end
    end

    assign credit_used   = {1'b0, occ_q} + {1'b0, inflight};
    assign issue         = ~rst & ~bus.redirect & (credit_used < DEPTH_C);
    // Data returning in a redirect cycle belongs to the flushed stream.
    assign push          = tag_valid_q[MEM_LAT-1] & ~bus.redirect;
    assign bus.out_valid = (occ_q != '0) & ~bus.redirect;
    assign pop           = bus.out_valid & bus.out_ready;

    assign bus.imem_en   = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_instr = fifo_instr_q[rd_ptr_q];
    assign bus.out_pc    = fifo_pc_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
    end

    // Tag pipeline: stage 0 captures the issuing PC; the last stage lines up
    // with the cycle in which imem_rdata carries that PC's word.
    for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            assign tag_valid_d[gi] = issue;
            assign tag_pc_d[gi]    = fetch_pc_q;
        end else begin : g_shift
            assign tag_valid_d[gi] = tag_valid_q[gi-1] & ~bus.redirect;
            assign tag_pc_d[gi]    = tag_pc_q[gi-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                tag_valid_q[gi] <= 1'b0;
            end else begin
                tag_valid_q[gi] <= tag_valid_d[gi];
            end
            tag_pc_q[gi] <= tag_pc_d[gi];
        end
    end

    // FIFO storage: only the entry at the write pointer changes on a push.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
        assign fifo_instr_d[gi] = (push && wr_ptr_q == PTR_W'(gi)) ? bus.imem_rdata
                                                                  : fifo_instr_q[gi];
        assign fifo_pc_d[gi]    = (push && wr_ptr_q == PTR_W'(gi)) ? tag_pc_q[MEM_LAT-1]
                                                                  : fifo_pc_q[gi];

        always_ff @(posedge clk) begin
            fifo_instr_q[gi] <= fifo_instr_d[gi];
            fifo_pc_q[gi]    <= fifo_pc_d[gi];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (bus.redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Everything buffered or in flight at a redirect is discarded.
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(pop);
        flush_count_d = flush_count_q;
        if (bus.redirect) begin
            flush_count_d = flush_count_q + 32'(credit_used);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit (PC_W=15, MEM_LAT=2, DEPTH=4).
//   Reference model: after reset the instruction stream is RESET_PC, +1, ...
//   and after a redirect it is redirect_pc, +1, ... (mod 2^15); every word
//   equals its PC zero-extended. The monitor builds the expected stream into
//   a queue when it sees reset/redirect stimulus and pops it on every
//   accepted output.
// ----------------------------------------------------------------------------
module tb_fetch_unit;
    localparam int PC_W    = 15;
    localparam int INSTR_W = 32;
    localparam int MEM_LAT = 2;
    localparam int DEPTH   = 4;
    localparam logic [PC_W-1:0] RESET_PC = 15'h7FFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, flush_count;
`endif

    fetch_unit #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_LAT(MEM_LAT), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count(fetch_count),
        .flush_count(flush_count)
`endif
    );

    // Instruction memory: word at addr is {17'b0, addr}, MEM_LAT cycles later.
    logic [INSTR_W-1:0] mem_pipe [MEM_LAT];
    always @(posedge clk) begin
        mem_pipe[0] <= bus.imem_en ? {17'b0, bus.imem_addr} : 32'hDEAD_BEEF;
        for (int k = 1; k < MEM_LAT; k++) mem_pipe[k] <= mem_pipe[k-1];
    end
    assign bus.imem_rdata = mem_pipe[MEM_LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [PC_W-1:0] exp_q [$];
    logic [PC_W-1:0] gen_pc, exp_issue, exp_pc;
    int              issued_ep, popped_ep;
    logic [31:0]     pops_total, flush_total;

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 15'd1;
        end
    endtask

    task automatic new_epoch(input logic [PC_W-1:0] pc);
        exp_q.delete();
        gen_pc    = pc;
        exp_issue = pc;
        issued_ep = 0;
        popped_ep = 0;
        refill();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            new_epoch(RESET_PC);
            pops_total  = 0;
            flush_total = 0;
        end else begin
`ifdef FETCH_STATS_EN
            check("fetch_count", 64'(fetch_count), 64'(pops_total));
            check("flush_count", 64'(flush_count), 64'(flush_total));
`endif
            if (bus.redirect) begin
                check("redirect_no_pop", 64'(bus.out_valid), 64'd0);
                check("redirect_no_issue", 64'(bus.imem_en), 64'd0);
                flush_total = flush_total + 32'(issued_ep - popped_ep);
                new_epoch(bus.redirect_pc);
            end else begin
                if (bus.imem_en) begin
                    check("issue_addr", 64'(bus.imem_addr), 64'(exp_issue));
                    exp_issue = exp_issue + 15'd1;
                    issued_ep++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    exp_pc = exp_q.pop_front();
                    refill();
                    check("out_pc", 64'(bus.out_pc), 64'(exp_pc));
                    check("out_instr", 64'(bus.out_instr), 64'({17'b0, exp_pc}));
                    pops_total = pops_total + 32'd1;
                    popped_ep++;
                end
                check("no_overflow", 64'((issued_ep - popped_ep) > DEPTH), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_imem_en", 64'(bus.imem_en), 64'd0);
        end
        drive_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("first_issue_en", 64'(bus.imem_en), 64'd1);
        check("first_issue_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        check("lat_c0", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("lat_c1", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("lat_c2", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_c3", 64'(bus.out_valid), 64'd1);
        check("first_pc", 64'(bus.out_pc), 64'(RESET_PC));

        // Stream across the wrap at one instruction per cycle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stream_throughput", 64'(bus.out_valid), 64'd1);
        end

        // Backpressure
        drive_cycle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("bp_issue_stopped", 64'(bus.imem_en), 64'd0);
        check("bp_valid_held", 64'(bus.out_valid), 64'd1);
        check("bp_full_credit", 64'(issued_ep - popped_ep), 64'(DEPTH));
        drive_cycle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_release_stream", 64'(bus.out_valid), 64'd1);
        end

        // Single redirect mid-stream
        drive_cycle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 15'h0100;
        @(negedge clk);
        drive_cycle();
        bus.redirect = 1'b0;
        @(negedge clk);
        check("redir_issue_en", 64'(bus.imem_en), 64'd1);
        check("redir_issue_addr", 64'(bus.imem_addr), 64'h0100);
        check("redir_lat_r1", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("redir_lat_r2", 64'(bus.out_valid), 64'd0);
        @(negedge clk); check("redir_lat_r3", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("redir_lat_r4", 64'(bus.out_valid), 64'd1);
        check("redir_first_pc", 64'(bus.out_pc), 64'h0100);
        for (int i = 0; i < 6; i++) @(negedge clk);

        // Back-to-back redirects: the last one wins
        drive_cycle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 15'h0200;
        drive_cycle();
        bus.redirect_pc = 15'h0300;
        drive_cycle();
        bus.redirect = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("b2b_valid_seen", 64'(seen), 64'd1);
        check("b2b_pc", 64'(bus.out_pc), 64'h0300);
        for (int i = 0; i < 5; i++) @(negedge clk);

        // Reset mid-stream with redirect also asserted
        drive_cycle();
        rst             = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 15'h0555;
        drive_cycle();
        @(negedge clk);
        check("rst_redir_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_redir_imem_en", 64'(bus.imem_en), 64'd0);
        drive_cycle();
        rst          = 1'b0;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("rst_redir_first_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        check("rst_redir_first_en", 64'(bus.imem_en), 64'd1);

        // Fill, then push and pop together while ready toggles
        drive_cycle();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive_cycle();
        for (int i = 0; i < 30; i++) begin
            bus.out_ready = ~bus.out_ready;
            drive_cycle();
        end

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 15'h7FFD : 15'($urandom);
            rst             = ($urandom_range(0, 299) == 0);
            drive_cycle();
        end
        rst           = 1'b0;
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) drive_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
